// File: rtl/dff_ctrl_pkg.sv
// Shared definitions for the DFF clear/preset pin generator.
// Holds the FSM state encoding and the hold-counter width helper.
package dff_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        CLR_ACT  = 3'd2,
        PRE_ACT  = 3'd3,
        GAP      = 3'd4
    } dff_state_e;

    // Bits needed for a counter that must represent 0..hold_cycles without wrapping.
    function automatic int hold_cnt_width(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/dff_clr_pre_gen_rst_sync.sv
// Reset synchroniser: asserts asynchronously with CLR low and releases
// SYNC_STAGES rising edges after CLR goes high.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic CLR,
    output logic CLR_SYNC
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift ones in after release; any CLR low empties the chain at once.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign CLR_SYNC = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/dff_clr_pre_gen.sv
// Generator for the active-low asynchronous CLR/PRE pins of downstream flops.
// Synchronises master reset release, stretches clear/preset pulses to
// HOLD_CYCLES and never drives both outputs low together.
// Optional: define DFF_CLR_PRE_GEN_CONFLICT_CNT_EN to add CONFLICT_CNT[7:0].
module dff_clr_pre_gen
    import dff_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 3
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CLR_REQ,
    input  logic       PRE_REQ,
    output logic       CLR_O,
    output logic       PRE_O,
    output logic       BUSY,
    output logic       CONFLICT
`ifdef DFF_CLR_PRE_GEN_CONFLICT_CNT_EN
    ,
    output logic [7:0] CONFLICT_CNT
`endif
);

    localparam int CW = hold_cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic          clr_sync_s;
    dff_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic          clr_o_r;
    logic          pre_o_r;
    logic          busy_r;
    logic          conflict_r;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .CLK      (CLK),
        .CLR      (CLR),
        .CLR_SYNC (clr_sync_s)
    );

    // Sequencer: reset hold, request arbitration, pulse stretch and break-before-make gap.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r    <= RST_HOLD;
            cnt_r      <= CNT_ZERO;
            clr_o_r    <= 1'b0;
            pre_o_r    <= 1'b1;
            busy_r     <= 1'b1;
            conflict_r <= 1'b0;
        end else begin
            conflict_r <= 1'b0;
            case (state_r)
                RST_HOLD: begin
                    // Clear stays low until the synchronised release plus the hold time.
                    if (clr_sync_s) begin
                        if (cnt_r == HOLD_MAX) begin
                            state_r <= IDLE;
                            cnt_r   <= CNT_ZERO;
                            clr_o_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_r <= CNT_ZERO;
                    end
                end
                IDLE: begin
                    // Clear wins when both requests arrive together.
                    if (CLR_REQ) begin
                        state_r    <= CLR_ACT;
                        cnt_r      <= CNT_ONE;
                        clr_o_r    <= 1'b0;
                        pre_o_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        conflict_r <= PRE_REQ;
                    end else if (PRE_REQ) begin
                        state_r <= PRE_ACT;
                        cnt_r   <= CNT_ONE;
                        clr_o_r <= 1'b1;
                        pre_o_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        clr_o_r <= 1'b1;
                        pre_o_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                CLR_ACT, PRE_ACT: begin
                    // Counter was loaded with 1 on entry, so HOLD_MAX marks the last low cycle.
                    if (cnt_r == HOLD_MAX) begin
                        state_r <= GAP;
                        cnt_r   <= CNT_ZERO;
                        clr_o_r <= 1'b1;
                        pre_o_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                    clr_o_r <= 1'b1;
                    pre_o_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    // Corrupted state: fall back to holding downstream flops in clear.
                    state_r <= RST_HOLD;
                    cnt_r   <= CNT_ZERO;
                    clr_o_r <= 1'b0;
                    pre_o_r <= 1'b1;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign CLR_O    = clr_o_r;
    assign PRE_O    = pre_o_r;
    assign BUSY     = busy_r;
    assign CONFLICT = conflict_r;

`ifdef DFF_CLR_PRE_GEN_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt_r;

    // Count conflicting requests accepted in IDLE, saturating rather than wrapping.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            conflict_cnt_r <= 8'h00;
        end else if ((state_r == IDLE) && CLR_REQ && PRE_REQ && (conflict_cnt_r != 8'hFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 8'h01;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign CONFLICT_CNT = conflict_cnt_r;
`else
    // Without the counter, the CONFLICT pulse is the only conflict indication.
`endif

endmodule

// File: tb/tb_dff_clr_pre_gen.sv
// Self-checking bench for dff_clr_pre_gen (SYNC_STAGES=2, HOLD_CYCLES=3).
// Expected outputs come from a timeline model: edges counted since reset
// release and the edge index at which the current sequence started.
module tb_dff_clr_pre_gen;

    localparam int S = 2;
    localparam int H = 3;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       CLR_REQ = 1'b0;
    logic       PRE_REQ = 1'b0;
    logic       CLR_O;
    logic       PRE_O;
    logic       BUSY;
    logic       CONFLICT;
`ifdef DFF_CLR_PRE_GEN_CONFLICT_CNT_EN
    logic [7:0] CONFLICT_CNT;
`endif

    int errors = 0;
    int checks = 0;

    // Timeline model state
    int k = 0;       // edges completed since reset release
    int s = -1;      // edge index of current/last sequence start, -1 if none
    bit s_clr = 1'b0;
    bit s_both = 1'b0;
    int m_cnt = 0;   // expected conflict count (saturating at 255)

    dff_clr_pre_gen #(
        .SYNC_STAGES (S),
        .HOLD_CYCLES (H)
    ) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .CLR_REQ      (CLR_REQ),
        .PRE_REQ      (PRE_REQ),
        .CLR_O        (CLR_O),
        .PRE_O        (PRE_O),
        .BUSY         (BUSY),
        .CONFLICT     (CONFLICT)
`ifdef DFF_CLR_PRE_GEN_CONFLICT_CNT_EN
        ,
        .CONFLICT_CNT (CONFLICT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        s = -1;
        s_clr = 1'b0;
        s_both = 1'b0;
        m_cnt = 0;
    endtask

    task automatic check_outputs(input logic clr, input int kk);
        logic e_clr, e_pre, e_busy, e_conf;
        bit in_pulse;
        if (!clr) begin
            e_clr = 1'b0; e_pre = 1'b1; e_busy = 1'b1; e_conf = 1'b0;
        end else if (s < 0) begin
            e_clr  = (kk >= S + H);
            e_pre  = 1'b1;
            e_busy = !(kk >= S + H);
            e_conf = 1'b0;
        end else begin
            in_pulse = (kk >= s) && (kk <= s + H - 1);
            e_clr  = !(in_pulse && s_clr);
            e_pre  = !(in_pulse && !s_clr);
            e_busy = (kk <= s + H);
            e_conf = (kk == s) && s_both;
        end
        check("clr_o", {7'd0, CLR_O}, {7'd0, e_clr});
        check("pre_o", {7'd0, PRE_O}, {7'd0, e_pre});
        check("busy", {7'd0, BUSY}, {7'd0, e_busy});
        check("conflict", {7'd0, CONFLICT}, {7'd0, e_conf});
        check("never_both_low", {7'd0, !(CLR_O == 1'b0 && PRE_O == 1'b0)}, 8'd1);
`ifdef DFF_CLR_PRE_GEN_CONFLICT_CNT_EN
        check("conflict_cnt", CONFLICT_CNT, 8'(m_cnt));
`endif
    endtask

    // One clock cycle: drive at negedge, model the rising edge, sample 1ns later.
    task automatic step(input logic clr, input logic creq, input logic preq);
        int kk;
        bit idle;
        @(negedge CLK);
        CLR = clr;
        CLR_REQ = creq;
        PRE_REQ = preq;
        if (!clr) model_reset();
        @(posedge CLK);
        kk = k;
        if (clr) begin
            if (s < 0) idle = (k >= S + H + 1);
            else       idle = (k >= s + H + 2);
            if (idle && (creq || preq)) begin
                s = k;
                s_clr = creq;
                s_both = creq && preq;
                if (s_both && m_cnt < 255) m_cnt++;
            end
            k++;
        end
        #1;
        check_outputs(clr, kk);
    endtask

    // Drop CLR between edges and check the outputs react without a clock edge.
    task automatic async_reset();
        #2;
        CLR = 1'b0;
        model_reset();
        #1;
        check("async_clr_o", {7'd0, CLR_O}, 8'd0);
        check("async_pre_o", {7'd0, PRE_O}, 8'd1);
        check("async_busy", {7'd0, BUSY}, 8'd1);
        check("async_conflict", {7'd0, CONFLICT}, 8'd0);
    endtask

    initial begin
        // Reset held for 3 cycles, then release and wait for IDLE
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

        // Single clear pulse
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);

        // Conflict: clear wins, CONFLICT pulses once
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);

        // Preset held continuously: back-to-back pulses with a gap
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a preset pulse
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);

        // Randomised requests with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1'b0, 1'b0, 1'b0);
            end else begin
                step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            end
        end

        // Saturate the conflict counter: 300+ conflicts with both requests held
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300 * (H + 2) + 10; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
`ifdef DFF_CLR_PRE_GEN_CONFLICT_CNT_EN
        check("conflict_cnt_sat", CONFLICT_CNT, 8'hFF);
`endif
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
